// File: rtl/sprite_regs_pkg.sv
// Shared definitions for the sprite engine register map and the command loader.
// Holds register addresses, control bits, write-size codes, header opcodes and loader states.
package sprite_regs_pkg;

  typedef enum logic [5:0] {
    REG_CTRL      = 6'h00,
    REG_SPR0_POS  = 6'h04,
    REG_SPR0_BMP0 = 6'h06,
    REG_SPR0_BMP1 = 6'h08,
    REG_SPR0_BMP2 = 6'h0A,
    REG_SPR0_BMP3 = 6'h0C,
    REG_SPR1_POS  = 6'h0E,
    REG_SPR1_BMP0 = 6'h10,
    REG_SPR1_BMP1 = 6'h12,
    REG_SPR1_BMP2 = 6'h14,
    REG_SPR1_BMP3 = 6'h16
  } sprite_reg_e;

  typedef enum int {
    CTRL_STREAM_EN = 0,
    CTRL_IRQ_EN    = 1,
    CTRL_BIT2      = 2
  } ctrl_bit_e;

  typedef enum logic [1:0] {
    WN_8    = 2'b00,
    WN_16   = 2'b01,
    WN_IDLE = 2'b11
  } wsize_e;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_W16  = 2'b01,
    OP_CTRL = 2'b10,
    OP_BAD  = 2'b11
  } opcode_e;

  typedef enum logic [2:0] {
    ST_HDR    = 3'd0,
    ST_LO     = 3'd1,
    ST_HI     = 3'd2,
    ST_CPAY   = 3'd3,
    ST_PAUSE  = 3'd4,
    ST_WR     = 3'd5,
    ST_RESUME = 3'd6,
    ST_CWR    = 3'd7
  } state_e;

  // 16-bit writes may only target the even sprite registers.
  function automatic logic addr_valid(input logic [5:0] a);
    return (a >= REG_SPR0_POS) && (a <= REG_SPR1_BMP3) && (a[0] == 1'b0);
  endfunction

endpackage

// File: rtl/sprite_cmd_if.sv
// Byte-stream input and engine register-bus output of the sprite command loader.
interface sprite_cmd_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  bus_address;
  logic [31:0] bus_data;
  logic [1:0]  bus_write_n;

  modport master (
    output in_data, in_valid,
    input  in_ready, bus_address, bus_data, bus_write_n
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, bus_address, bus_data, bus_write_n
  );
endinterface

// File: rtl/sprite_cmd_loader.sv
// Parses a command byte stream into sprite engine register writes, optionally
// pausing video streaming around 16-bit configuration writes.
module sprite_cmd_loader
  import sprite_regs_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int AUTO_PAUSE     = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  sprite_cmd_if.slave    cmd,
  output logic           busy,
  output logic [2:0]     ctrl_shadow,
  output logic           err_sticky,
  input  logic           err_clear,
  output logic [7:0]     pkt_count
);

  // Abort fires on the edge where the idle counter would reach TIMEOUT_CYCLES-1.
  localparam logic [19:0] TO_LAST = 20'(TIMEOUT_CYCLES - 2);

  state_e      state_r, state_s;
  logic [5:0]  addr_r, addr_s;
  logic [7:0]  lo_r, lo_s, hi_r, hi_s;
  logic        paused_r, paused_s;
  logic        addr_ok_r, addr_ok_s;
  logic [2:0]  shadow_r, shadow_s;
  logic        err_r, err_set_s;
  logic [7:0]  pkt_r;
  logic        pkt_inc_s;
  logic [19:0] to_cnt_r, to_cnt_s;
  logic        in_ready_r, in_ready_s;
  logic        busy_r;
  logic        accept_s;
  logic [5:0]  bus_addr_r, bus_addr_s;
  logic [31:0] bus_data_r, bus_data_s;
  logic [1:0]  bus_wn_r, bus_wn_s;

  assign accept_s = cmd.in_valid & in_ready_r;

  // Next-state, payload capture, error and timeout decisions.
  always_comb begin
    state_s   = state_r;
    addr_s    = addr_r;
    lo_s      = lo_r;
    hi_s      = hi_r;
    paused_s  = paused_r;
    addr_ok_s = addr_ok_r;
    shadow_s  = shadow_r;
    err_set_s = 1'b0;
    pkt_inc_s = 1'b0;
    to_cnt_s  = 20'd0;
    case (state_r)
      ST_HDR: begin
        if (accept_s) begin
          case (opcode_e'(cmd.in_data[7:6]))
            OP_NOP:  state_s = ST_HDR;
            OP_W16: begin
              addr_s    = cmd.in_data[5:0];
              addr_ok_s = addr_valid(cmd.in_data[5:0]);
              paused_s  = 1'b0;
              state_s   = ST_LO;
            end
            OP_CTRL: state_s = ST_CPAY;
            default: err_set_s = 1'b1;
          endcase
        end else begin
          state_s = ST_HDR;
        end
      end
      ST_LO, ST_HI, ST_CPAY: begin
        if (accept_s) begin
          if (state_r == ST_LO) begin
            lo_s    = cmd.in_data;
            state_s = ST_HI;
          end else if (state_r == ST_HI) begin
            hi_s = cmd.in_data;
            if (!addr_ok_r) begin
              err_set_s = 1'b1;
              state_s   = ST_HDR;
            end else if ((AUTO_PAUSE != 0) && shadow_r[CTRL_STREAM_EN]) begin
              paused_s = 1'b1;
              state_s  = ST_PAUSE;
            end else begin
              state_s = ST_WR;
            end
          end else begin
            shadow_s = cmd.in_data[2:0];
            state_s  = ST_CWR;
          end
        end else if (to_cnt_r == TO_LAST) begin
          err_set_s = 1'b1;
          state_s   = ST_HDR;
        end else begin
          to_cnt_s = to_cnt_r + 20'd1;
        end
      end
      ST_PAUSE: state_s = ST_WR;
      ST_WR: begin
        if (paused_r) begin
          state_s = ST_RESUME;
        end else begin
          pkt_inc_s = 1'b1;
          state_s   = ST_HDR;
        end
      end
      ST_RESUME, ST_CWR: begin
        pkt_inc_s = 1'b1;
        state_s   = ST_HDR;
      end
      default: state_s = ST_HDR;
    endcase
  end

  // Bus contents for the cycle about to start, so the bus registers line up with the state.
  always_comb begin
    bus_addr_s = 6'h00;
    bus_data_s = 32'h0000_0000;
    bus_wn_s   = WN_IDLE;
    in_ready_s = (state_s == ST_HDR) || (state_s == ST_LO) ||
                 (state_s == ST_HI)  || (state_s == ST_CPAY);
    case (state_s)
      ST_PAUSE: begin
        bus_wn_s   = WN_8;
        bus_data_s = {29'd0, shadow_r[2:1], 1'b0};
      end
      ST_WR: begin
        bus_addr_s = addr_s;
        bus_wn_s   = WN_16;
        bus_data_s = {16'h0000, hi_s, lo_s};
      end
      ST_RESUME: begin
        bus_wn_s   = WN_8;
        bus_data_s = {29'd0, shadow_r};
      end
      ST_CWR: begin
        bus_wn_s   = WN_8;
        bus_data_s = {29'd0, shadow_s};
      end
      default: bus_wn_s = WN_IDLE;
    endcase
  end

  // State, payload, status and registered bus outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_HDR;
      addr_r     <= 6'h00;
      lo_r       <= 8'h00;
      hi_r       <= 8'h00;
      paused_r   <= 1'b0;
      addr_ok_r  <= 1'b0;
      shadow_r   <= 3'd0;
      err_r      <= 1'b0;
      pkt_r      <= 8'd0;
      to_cnt_r   <= 20'd0;
      in_ready_r <= 1'b0;
      busy_r     <= 1'b0;
      bus_addr_r <= 6'h00;
      bus_data_r <= 32'h0000_0000;
      bus_wn_r   <= WN_IDLE;
    end else begin
      state_r    <= state_s;
      addr_r     <= addr_s;
      lo_r       <= lo_s;
      hi_r       <= hi_s;
      paused_r   <= paused_s;
      addr_ok_r  <= addr_ok_s;
      shadow_r   <= shadow_s;
      err_r      <= err_set_s ? 1'b1 : (err_clear ? 1'b0 : err_r);
      pkt_r      <= pkt_inc_s ? pkt_r + 8'd1 : pkt_r;
      to_cnt_r   <= to_cnt_s;
      in_ready_r <= in_ready_s;
      busy_r     <= (state_s != ST_HDR);
      bus_addr_r <= bus_addr_s;
      bus_data_r <= bus_data_s;
      bus_wn_r   <= bus_wn_s;
    end
  end

  assign cmd.in_ready    = in_ready_r;
  assign cmd.bus_address = bus_addr_r;
  assign cmd.bus_data    = bus_data_r;
  assign cmd.bus_write_n = bus_wn_r;
  assign busy            = busy_r;
  assign ctrl_shadow     = shadow_r;
  assign err_sticky      = err_r;
  assign pkt_count       = pkt_r;

endmodule
